// File: rtl/riscv_irq_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_irq_arbiter
//   Collects 32 interrupt lines into a pending register, gates them with a
//   software mask and reports the highest-priority (lowest index) request to
//   the core through registered outputs.
//
//   Lines selected by EDGE_MASK are rising-edge triggered and stay pending
//   until the core acknowledges them. The remaining lines are level
//   triggered: they follow irq_i and ignore acknowledges.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active-high
//   irq_i         raw interrupt lines, synchronous to clk
//   irq_sec_i     per-line secure attribute
//   mask_we_i     mask register write strobe
//   mask_wdata_i  new mask value, 1 enables the line
//   irq_ack_i     core acknowledges the interrupt irq_ack_id_i
//   irq_ack_id_i  id being acknowledged
//   irq_pending_o a masked pending interrupt exists (registered)
//   irq_id_o      id of the winning interrupt (registered)
//   irq_sec_o     secure bit of the winning interrupt (registered)
//   pending_o     raw pending register for CSR readback
// -----------------------------------------------------------------------------
module riscv_irq_arbiter #(
    parameter int unsigned PULP_SECURE = 0,
    parameter logic [31:0] EDGE_MASK   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] irq_i,
    input  logic [31:0] irq_sec_i,
    input  logic        mask_we_i,
    input  logic [31:0] mask_wdata_i,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_ack_id_i,
    output logic        irq_pending_o,
    output logic [4:0]  irq_id_o,
    output logic        irq_sec_o,
    output logic [31:0] pending_o
);

    localparam int unsigned NUM_IRQ = 32;
    localparam int unsigned ID_W    = 5;

    localparam logic [NUM_IRQ-1:0] LEVEL_MASK = ~EDGE_MASK;

    // State registers
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    // Low for the first cycle after reset release so that a line already
    // high when reset drops is not mistaken for a rising edge.
    logic               r_armed;

    // Combinational helpers
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_ack_onehot;
    logic [NUM_IRQ-1:0] w_edge_next;
    logic [NUM_IRQ-1:0] w_pending_next;
    logic [NUM_IRQ-1:0] w_act;
    logic               w_any;
    logic [ID_W-1:0]    w_win_id;
    logic               w_win_sec;

    // Rising-edge detection against last cycle's sample
    always_comb begin
        w_edge = '0;
        if (r_armed) begin
            w_edge = irq_i & ~r_irq_prev;
        end
    end

    // Decode the acknowledge into a one-hot clear vector
    always_comb begin
        w_ack_onehot = '0;
        if (irq_ack_i) begin
            w_ack_onehot[irq_ack_id_i] = 1'b1;
        end
    end

    // Edge lines: a new edge beats a simultaneous acknowledge.
    // Level lines: simply follow the input, so acks have no effect on them.
    always_comb begin
        w_edge_next    = w_edge | (r_pending & ~w_ack_onehot);
        w_pending_next = (EDGE_MASK & w_edge_next) | (LEVEL_MASK & irq_i);
    end

    // Masking only gates what is presented to the core
    always_comb begin
        w_act = r_pending & r_mask;
        w_any = |w_act;
    end

    // Fixed priority: lowest set index wins
    always_comb begin
        w_win_id = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

    // Secure attribute of the winner, tied low when security is disabled
    always_comb begin
        w_win_sec = 1'b0;
        if (PULP_SECURE != 0) begin
            w_win_sec = irq_sec_i[w_win_id];
        end
    end

    // Input history, pending and mask registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_irq_prev <= irq_i;
            r_pending  <= w_pending_next;
            r_armed    <= 1'b1;
            if (mask_we_i) begin
                r_mask <= mask_wdata_i;
            end
        end
    end

    // Registered request towards the core; id/sec hold while nothing is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pending_o <= 1'b0;
            irq_id_o      <= '0;
            irq_sec_o     <= 1'b0;
        end else begin
            irq_pending_o <= w_any;
            if (w_any) begin
                irq_id_o  <= w_win_id;
                irq_sec_o <= w_win_sec;
            end
        end
    end

    assign pending_o = r_pending;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_irq_arbiter
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A behavioural model tracks pending/mask/output state and is
//   compared against the DUT on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_riscv_irq_arbiter;

    localparam int unsigned    SEC  = 1;
    localparam logic [31:0]    EDGE = 32'hFFCF_FFEF;  // lines 4, 20, 21 level

    logic        clk;
    logic        rst;
    logic [31:0] irq_i;
    logic [31:0] irq_sec_i;
    logic        mask_we_i;
    logic [31:0] mask_wdata_i;
    logic        irq_ack_i;
    logic [4:0]  irq_ack_id_i;
    logic        irq_pending_o;
    logic [4:0]  irq_id_o;
    logic        irq_sec_o;
    logic [31:0] pending_o;

    riscv_irq_arbiter #(
        .PULP_SECURE (SEC),
        .EDGE_MASK   (EDGE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_i         (irq_i),
        .irq_sec_i     (irq_sec_i),
        .mask_we_i     (mask_we_i),
        .mask_wdata_i  (mask_wdata_i),
        .irq_ack_i     (irq_ack_i),
        .irq_ack_id_i  (irq_ack_id_i),
        .irq_pending_o (irq_pending_o),
        .irq_id_o      (irq_id_o),
        .irq_sec_o     (irq_sec_o),
        .pending_o     (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: state as seen after each rising edge
    // ------------------------------------------------------------------
    logic [31:0] m_prev  = '0;
    logic [31:0] m_pend  = '0;
    logic [31:0] m_mask  = '0;
    logic        m_armed = 1'b0;
    logic        m_valid = 1'b0;
    logic [4:0]  m_id    = '0;
    logic        m_sec   = 1'b0;
    logic [31:0] m_act;
    logic [31:0] m_low;
    logic [31:0] m_nxt;

    // Inputs are stable from just after the previous falling edge, so they are
    // exactly what the DUT sampled on the rising edge that just passed.
    always @(negedge clk) begin
        if (rst) begin
            m_prev  = '0;
            m_pend  = '0;
            m_mask  = '0;
            m_armed = 1'b0;
            m_valid = 1'b0;
            m_id    = '0;
            m_sec   = 1'b0;
        end else begin
            m_act   = m_pend & m_mask;
            m_valid = (m_act != 0);
            if (m_valid) begin
                m_low = m_act & (~m_act + 32'd1);
                m_id  = 5'($clog2(m_low));
                m_sec = (SEC != 0) ? irq_sec_i[m_id] : 1'b0;
            end
            for (int n = 0; n < 32; n++) begin
                if (!EDGE[n])
                    m_nxt[n] = irq_i[n];
                else if (m_armed && irq_i[n] && !m_prev[n])
                    m_nxt[n] = 1'b1;
                else if (irq_ack_i && (irq_ack_id_i == 5'(n)))
                    m_nxt[n] = 1'b0;
                else
                    m_nxt[n] = m_pend[n];
            end
            m_pend  = m_nxt;
            m_prev  = irq_i;
            m_armed = 1'b1;
            if (mask_we_i) m_mask = mask_wdata_i;
        end
        chk("pending_o",     pending_o,            m_pend);
        chk("irq_pending_o", 32'(irq_pending_o),   32'(m_valid));
        chk("irq_id_o",      32'(irq_id_o),        32'(m_id));
        chk("irq_sec_o",     32'(irq_sec_o),       32'(m_sec));
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write_mask(input logic [31:0] v);
        mask_we_i    = 1'b1;
        mask_wdata_i = v;
        step();
        mask_we_i    = 1'b0;
    endtask

    task automatic ack(input logic [4:0] id);
        irq_ack_i    = 1'b1;
        irq_ack_id_i = id;
        step();
        irq_ack_i    = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        irq_i        = '0;
        irq_sec_i    = '0;
        mask_we_i    = 1'b0;
        mask_wdata_i = '0;
        irq_ack_i    = 1'b0;
        irq_ack_id_i = '0;

        // Reset state
        steps(3);
        chk("rst_pending",  32'(irq_pending_o), 32'd0);
        chk("rst_id",       32'(irq_id_o),      32'd0);
        chk("rst_pend_reg", pending_o,          32'd0);
        rst = 1'b0;
        steps(2);
        write_mask(32'hFFFF_FFFF);
        step();

        // Edge latency on line 5
        irq_i[5] = 1'b1;
        step();
        irq_i[5] = 1'b0;
        chk("edge_t1_pend5", 32'(pending_o[5]),   32'd1);
        chk("edge_t1_req",   32'(irq_pending_o),  32'd0);
        step();
        chk("edge_t2_req",   32'(irq_pending_o),  32'd1);
        chk("edge_t2_id",    32'(irq_id_o),       32'd5);
        steps(3);
        chk("edge_hold_id",  32'(irq_id_o),       32'd5);
        ack(5'd5);
        chk("ack5_pend",     pending_o,           32'd0);
        step();
        chk("ack5_req",      32'(irq_pending_o),  32'd0);

        // Priority: 3 beats 9, then 9 after ack
        irq_i[3] = 1'b1;
        irq_i[9] = 1'b1;
        step();
        irq_i[3] = 1'b0;
        irq_i[9] = 1'b0;
        step();
        chk("prio_id3",      32'(irq_id_o),       32'd3);
        ack(5'd3);
        step();
        chk("prio_id9",      32'(irq_id_o),       32'd9);
        ack(5'd9);
        step();
        chk("prio_done_req", 32'(irq_pending_o),  32'd0);
        chk("prio_hold_id",  32'(irq_id_o),       32'd9);

        // Ack of a non-pending id is ignored
        ack(5'd11);
        chk("stray_ack",     pending_o,           32'd0);

        // Simultaneous set and ack on line 7
        irq_i[7] = 1'b1;
        step();
        irq_i[7] = 1'b0;
        step();
        irq_i[7]     = 1'b1;
        irq_ack_i    = 1'b1;
        irq_ack_id_i = 5'd7;
        step();
        irq_i[7]  = 1'b0;
        irq_ack_i = 1'b0;
        chk("setwin_pend7",  32'(pending_o[7]),   32'd1);
        step();
        chk("setwin_req",    32'(irq_pending_o),  32'd1);
        ack(5'd7);
        step();

        // Masking
        write_mask(32'h0);
        irq_i[2] = 1'b1;
        step();
        irq_i[2] = 1'b0;
        chk("mask_pend2",    32'(pending_o[2]),   32'd1);
        step();
        chk("mask_req0",     32'(irq_pending_o),  32'd0);
        write_mask(32'h4);
        step();
        chk("unmask_req",    32'(irq_pending_o),  32'd1);
        chk("unmask_id",     32'(irq_id_o),       32'd2);
        ack(5'd2);
        write_mask(32'hFFFF_FFFF);
        step();

        // Level line 4 with secure attribute
        irq_sec_i[4] = 1'b1;
        irq_i[4]     = 1'b1;
        steps(2);
        chk("lvl_id4",       32'(irq_id_o),       32'd4);
        chk("lvl_sec",       32'(irq_sec_o),      32'd1);
        ack(5'd4);
        step();
        chk("lvl_ack_pend",  32'(pending_o[4]),   32'd1);
        chk("lvl_ack_req",   32'(irq_pending_o),  32'd1);
        irq_i[4] = 1'b0;
        steps(2);
        chk("lvl_drop_req",  32'(irq_pending_o),  32'd0);
        irq_sec_i = '0;

        // Reset mid-operation
        irq_i[6] = 1'b1;
        irq_i[8] = 1'b1;
        step();
        irq_i[6] = 1'b0;
        irq_i[8] = 1'b0;
        step();
        chk("pre_rst_id",    32'(irq_id_o),       32'd6);
        irq_i[1] = 1'b1;
        irq_i[4] = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_req",     32'(irq_pending_o),  32'd0);
        chk("async_id",      32'(irq_id_o),       32'd0);
        chk("async_pend",    pending_o,           32'd0);
        step();
        rst = 1'b0;
        write_mask(32'hFFFF_FFFF);
        chk("rel_pend",      pending_o,           32'h10);
        step();
        chk("rel_id4",       32'(irq_id_o),       32'd4);
        steps(2);
        chk("rel_no_edge1",  32'(pending_o[1]),   32'd0);
        irq_i[1] = 1'b0;
        step();
        irq_i[1] = 1'b1;
        step();
        chk("rel_edge1",     pending_o,           32'h12);
        step();
        chk("rel_id1",       32'(irq_id_o),       32'd1);
        irq_i = '0;
        ack(5'd1);
        steps(2);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            irq_i        = irq_i ^ ($urandom & $urandom & $urandom);
            irq_sec_i    = $urandom;
            irq_ack_i    = ($urandom_range(0, 2) == 0);
            irq_ack_id_i = ($urandom_range(0, 1) == 0) ? m_id : 5'($urandom_range(0, 31));
            mask_we_i    = ($urandom_range(0, 40) == 0);
            mask_wdata_i = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
            rst          = ($urandom_range(0, 600) == 0);
            step();
        end
        rst       = 1'b0;
        irq_i     = '0;
        irq_ack_i = 1'b0;
        mask_we_i = 1'b0;
        steps(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
